des_round_sequencer: RTL

- Sequences the 16 Feistel rounds of one DES block through the shared round function (expansion, S-boxes, PBox).
- Holds the L/R halves and the C/D key halves, and applies the per-round key rotation schedule for encrypt or decrypt.
- The f-function, PC2, IP and FP sit outside this block:
  - the block presents R and the current C/D to the f-function;
  - the f-function returns f_out combinationally.
- Sits between the Triple DES stage controller (valid/ready) and the round datapath.

---
 rtl/des_round_sequencer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/des_round_sequencer.sv
// Runs the 16 DES Feistel rounds of one block, one round per cycle, through an external f-function.
// Latency: 16 busy cycles from accept to out_valid; the result is held until out_ready, then one IDLE cycle follows.
module des_round_sequencer #(
    parameter logic [15:0] KEY_SHIFT_SCHED = 16'h8103
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_block,
    input  logic [55:0] in_key_cd,
    input  logic        in_decrypt,
    output logic [31:0] f_r,
    output logic [55:0] f_cd,
    input  logic [31:0] f_out,
    output logic [3:0]  round_idx,
    output logic        busy,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_block
);
    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    state_t      state_q;
    logic [31:0] l_q, r_q;
    logic [55:0] cd_q;
    logic [3:0]  round_q;
    logic        dec_q;
    logic [63:0] out_block_q;
    logic        out_valid_q, busy_q, in_ready_q;

    logic [31:0] r_d;
    logic [55:0] cd_d, cd_load;
    logic        shift_one_enc, shift_one_dec;

    function automatic logic [27:0] rotl28(input logic [27:0] x, input logic one);
        return one ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic one);
        return one ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
    endfunction

    // Encrypt rotates ahead to the next round's key; decrypt walks the schedule backwards.
    always_comb begin
        r_d           = l_q ^ f_out;
        shift_one_enc = KEY_SHIFT_SCHED[round_q + 4'd1];
        shift_one_dec = KEY_SHIFT_SCHED[4'd15 - round_q];
        if (dec_q) begin
            cd_d = {rotr28(cd_q[55:28], shift_one_dec), rotr28(cd_q[27:0], shift_one_dec)};
        end else begin
            cd_d = {rotl28(cd_q[55:28], shift_one_enc), rotl28(cd_q[27:0], shift_one_enc)};
        end
        if (in_decrypt) begin
            cd_load = in_key_cd;
        end else begin
            cd_load = {rotl28(in_key_cd[55:28], 1'b1), rotl28(in_key_cd[27:0], 1'b1)};
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            l_q         <= '0;
            r_q         <= '0;
            cd_q        <= '0;
            round_q     <= '0;
            dec_q       <= 1'b0;
            out_block_q <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        l_q        <= in_block[63:32];
                        r_q        <= in_block[31:0];
                        cd_q       <= cd_load;
                        dec_q      <= in_decrypt;
                        round_q    <= 4'd0;
                        busy_q     <= 1'b1;
                        in_ready_q <= 1'b0;
                        state_q    <= ROUND;
                    end
                end
                ROUND: begin
                    l_q <= r_q;
                    r_q <= r_d;
                    if (round_q == 4'd15) begin
                        // Preoutput swaps the halves: {R16, L16}.
                        out_block_q <= {r_d, r_q};
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= DONE;
                    end else begin
                        cd_q    <= cd_d;
                        round_q <= round_q + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_block = out_block_q;
    assign f_r       = r_q;
    assign f_cd      = cd_q;
    assign round_idx = round_q;

endmodule
